// File: rtl/tartaruga_pkg.sv
// Shared types and defaults for the shared-memory-port arbiter.
package tartaruga_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2,
      DROP = 2'd3
   } mem_arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } mem_owner_t;

   localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-outstanding memory port.
// Optional fetch anti-starvation counter: define MEM_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no transaction; selects an owner when a request is pending
// REQ   | mem_req_o driven with latched fields, waiting for mem_gnt_i
// RSP   | granted, waiting for mem_rvalid_i
// DROP  | flushed fetch already granted; swallow its mem_rvalid_i
module mem_arbiter
   import tartaruga_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_W-1:0]     if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [DATA_W/8-1:0]   dm_be_i,
   input  logic [ADDR_W-1:0]     dm_addr_i,
   input  logic [DATA_W-1:0]     dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [DATA_W-1:0]     dm_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [DATA_W/8-1:0]   mem_be_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   output logic                  busy_o
);

   localparam int BE_W = DATA_W / 8;

   mem_arb_state_t      state_q;
   mem_owner_t          owner_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   wdata_q;

   logic fetch_ok, pick_if, pick_dm, starve_hit;
   logic if_own, kill, in_req, in_rsp;

   assign fetch_ok = if_req_i && !flush_i;
   assign pick_if  = fetch_ok && (starve_hit || !dm_req_i);
   assign pick_dm  = dm_req_i && !pick_if;

   assign if_own = (owner_q == OWN_IF);
   assign kill   = flush_i && if_own;
   // Outputs are forced quiet while reset is held, whatever the old state was.
   assign in_req = (state_q == REQ) && !rst_i;
   assign in_rsp = (state_q == RSP) && !rst_i;

   assign if_gnt_o    = in_req && if_own && mem_gnt_i && !flush_i;
   assign dm_gnt_o    = in_req && !if_own && mem_gnt_i;
   assign if_rvalid_o = in_rsp && if_own && mem_rvalid_i && !flush_i;
   assign dm_rvalid_o = in_rsp && !if_own && mem_rvalid_i;
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

   assign mem_req_o   = in_req;
   assign mem_we_o    = in_req && we_q;
   assign mem_be_o    = in_req ? be_q : '0;
   assign mem_addr_o  = in_req ? addr_q : '0;
   assign mem_wdata_o = in_req ? wdata_q : '0;
   assign busy_o      = (state_q != IDLE) && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_dm) begin
                  state_q <= REQ;
                  owner_q <= OWN_DM;
                  addr_q  <= dm_addr_i;
                  we_q    <= dm_we_i;
                  be_q    <= dm_be_i;
                  wdata_q <= dm_wdata_i;
               end else if (pick_if) begin
                  state_q <= REQ;
                  owner_q <= OWN_IF;
                  addr_q  <= if_addr_i;
                  we_q    <= 1'b0;
                  be_q    <= '1;
                  wdata_q <= '0;
               end
            end
            REQ: begin
               // A flushed fetch that the memory already accepted still owes a response.
               if (kill)           state_q <= mem_gnt_i ? DROP : IDLE;
               else if (mem_gnt_i) state_q <= RSP;
            end
            RSP: begin
               if (mem_rvalid_i) state_q <= IDLE;
               else if (kill)    state_q <= DROP;
            end
            DROP: begin
               if (mem_rvalid_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || !if_req_i || if_gnt_o)
         starve_q <= '0;
      else if (dm_gnt_o && starve_q != CNT_W'(STARVE_LIMIT))
         starve_q <= starve_q + CNT_W'(1);
   end

   assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));
`else
   assign starve_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          flush_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o, if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          dm_req_i, dm_we_i;
   logic [BW-1:0] dm_be_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic          dm_gnt_o, dm_rvalid_o;
   logic [DW-1:0] dm_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [BW-1:0] mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i, mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          busy_o;

   int n_assert = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
      .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o, busy_o}, 64'h0);
      chk({tag, "_rdata"}, {if_rdata_o, dm_rdata_o}, 64'h0);
      chk({tag, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'h0);
      chk({tag, "_be"}, mem_be_o, 64'h0);
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_in();
      flush_i = 0; if_req_i = 0; if_addr_i = '0;
      dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   // random-phase model state
   bit            if_pend, dm_pend, if_out, dm_out, dm_w, mem_busy, issue;
   bit            prev_if, prev_dm, prev_mreq, exp_fetch;
   logic [AW-1:0] if_a, dm_a;
   logic [DW-1:0] dm_wd;
   logic [BW-1:0] dm_b;
   int            mem_cnt, done_cnt, sc, prev_sc, k;
   bit            rv_next;

   initial begin
      clr_in();
      rst_i = 1;
      cyc();
      if_req_i = 1; dm_req_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
      #1; chk_quiet("reset_hold");
      cyc();
      rst_i = 0; clr_in();
      #1; chk_quiet("post_reset");

      // lone fetch, minimum latency
      cyc(); if_req_i = 1; if_addr_i = 32'h100;
      #1; chk("f0_busy", busy_o, 0); chk("f0_memreq", mem_req_o, 0);
      cyc(); mem_gnt_i = 1;
      #1; chk("f1_memreq", mem_req_o, 1); chk("f1_addr", mem_addr_o, 32'h100);
      chk("f1_webe", {mem_we_o, mem_be_o}, 5'h0F); chk("f1_gnt", {if_gnt_o, dm_gnt_o}, 2'b10);
      chk("f1_busy", busy_o, 1);
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
      #1; chk("f2_rvalid", {if_rvalid_o, dm_rvalid_o}, 2'b10); chk("f2_rdata", if_rdata_o, 32'hDEAD_BEEF);
      chk("f2_busy", busy_o, 1); chk("f2_memreq", mem_req_o, 0);
      cyc(); clr_in();
      #1; chk("f3_busy", busy_o, 0); chk("f3_rvalid", {if_rvalid_o, dm_rvalid_o}, 2'b00);

      // simultaneous fetch and store: data first, fetch after one bubble
      cyc(); if_req_i = 1; if_addr_i = 32'h100;
      dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'hF; dm_addr_i = 32'h2000; dm_wdata_i = 32'h55AA;
      #1;
      cyc(); mem_gnt_i = 1;
      #1; chk("p1_addr", mem_addr_o, 32'h2000); chk("p1_we", mem_we_o, 1);
      chk("p1_wdata", mem_wdata_o, 32'h55AA); chk("p1_gnt", {if_gnt_o, dm_gnt_o}, 2'b01);
      cyc(); dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
      #1; chk("p2_rvalid", {if_rvalid_o, dm_rvalid_o}, 2'b01);
      cyc(); mem_rvalid_i = 0;
      #1; chk("p3_bubble", {mem_req_o, busy_o}, 2'b00);
      cyc(); mem_gnt_i = 1;
      #1; chk("p4_addr", {mem_we_o, mem_addr_o}, {1'b0, 32'h100}); chk("p4_gnt", {if_gnt_o, dm_gnt_o}, 2'b10);
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
      #1; chk("p5_rdata", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h1234});
      cyc(); clr_in();
      #1; chk("p6_busy", busy_o, 0);

      // flush while fetch in RSP, response two cycles later
      cyc(); if_req_i = 1; if_addr_i = 32'h300;
      #1;
      cyc(); mem_gnt_i = 1;
      #1; chk("d1_gnt", if_gnt_o, 1);
      cyc(); if_req_i = 0; mem_gnt_i = 0; flush_i = 1;
      #1; chk("d2_rvalid", if_rvalid_o, 0); chk("d2_busy", busy_o, 1);
      cyc(); flush_i = 0;
      #1; chk("d3_drop", {busy_o, mem_req_o}, 2'b10);
      cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA;
      #1; chk("d4_swallow", {if_rvalid_o, dm_rvalid_o, if_rdata_o}, 34'h0); chk("d4_busy", busy_o, 1);
      cyc(); clr_in();
      #1; chk("d5_idle", busy_o, 0);

      // flush with the response in the same RSP cycle
      cyc(); if_req_i = 1; if_addr_i = 32'h340;
      #1;
      cyc(); mem_gnt_i = 1;
      #1;
      cyc(); if_req_i = 0; mem_gnt_i = 0; flush_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h9;
      #1; chk("s2_rvalid", if_rvalid_o, 0);
      cyc(); clr_in();
      #1; chk("s3_idle", busy_o, 0);

      // flush with fetch in REQ, no grant
      cyc(); if_req_i = 1; if_addr_i = 32'h400;
      #1;
      cyc(); flush_i = 1;
      #1; chk("q1_gnt", if_gnt_o, 0); chk("q1_memreq", mem_req_o, 1);
      cyc(); clr_in();
      #1; chk("q2_dropped", {mem_req_o, busy_o}, 2'b00);

      // flush with fetch in REQ and grant in the same cycle
      cyc(); if_req_i = 1; if_addr_i = 32'h440;
      #1;
      cyc(); flush_i = 1; mem_gnt_i = 1;
      #1; chk("g1_gnt", if_gnt_o, 0);
      cyc(); if_req_i = 0; flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      #1; chk("g2_drop", {busy_o, mem_req_o, if_rvalid_o}, 3'b100);
      cyc(); clr_in();
      #1; chk("g3_idle", busy_o, 0);

      // flush has no effect on a data owner
      cyc(); dm_req_i = 1; dm_addr_i = 32'h500; dm_be_i = 4'h3;
      #1;
      cyc(); flush_i = 1;
      #1; chk("m1_hold", {mem_req_o, dm_gnt_o}, 2'b10);
      cyc(); flush_i = 0; mem_gnt_i = 1;
      #1; chk("m2_gnt", dm_gnt_o, 1); chk("m2_be", mem_be_o, 4'h3);
      cyc(); dm_req_i = 0; mem_gnt_i = 0; flush_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
      #1; chk("m3_rsp", {dm_rvalid_o, dm_rdata_o}, {1'b1, 32'h77});
      cyc(); clr_in();
      #1; chk("m4_idle", busy_o, 0);

      // flush blocks fetch selection in IDLE
      cyc(); if_req_i = 1; if_addr_i = 32'h480; flush_i = 1;
      #1;
      cyc(); flush_i = 0;
      #1; chk("b1_blocked", {mem_req_o, busy_o}, 2'b00);
      cyc(); mem_gnt_i = 1;
      #1; chk("b2_gnt", {mem_req_o, if_gnt_o, mem_addr_o}, {2'b11, 32'h480});
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      #1;
      cyc(); clr_in();
      #1;

      // both requesters held high: starvation behaviour
      cyc(); #1;
      k = 0; rv_next = 0;
      for (int c = 0; c < 60; c++) begin
         cyc();
         if_req_i = 1; if_addr_i = $urandom;
         dm_req_i = 1; dm_we_i = $urandom_range(0, 1); dm_addr_i = $urandom;
         dm_be_i = 4'hF; dm_wdata_i = $urandom;
         mem_rvalid_i = rv_next; rv_next = 0;
         mem_gnt_i = mem_req_o;
         #1;
         if (mem_gnt_i) begin
            exp_fetch = GUARD && (k % (LIMIT + 1) == LIMIT);
            chk($sformatf("starve_gnt%0d", k), {if_gnt_o, dm_gnt_o}, exp_fetch ? 2'b10 : 2'b01);
            k++;
            rv_next = 1;
         end
      end
      chk("starve_ngrants", k, 20);
      cyc(); clr_in(); mem_rvalid_i = rv_next;
      #1;
      cyc(); clr_in();
      #1; chk("starve_idle", busy_o, 0);

      // reset in RSP, stray response afterwards
      cyc(); if_req_i = 1; if_addr_i = 32'h600;
      #1;
      cyc(); mem_gnt_i = 1;
      #1; chk("r1_gnt", if_gnt_o, 1);
      cyc(); if_req_i = 0; mem_gnt_i = 0; rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF;
      #1; chk_quiet("rst_in_rsp");
      cyc(); rst_i = 0; mem_rvalid_i = 0;
      #1; chk_quiet("rst_release");
      cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF;
      #1; chk_quiet("rst_stray");
      cyc(); clr_in();
      #1; chk_quiet("rst_after");

      // randomized traffic against a transaction-level model
      if_pend = 0; dm_pend = 0; if_out = 0; dm_out = 0; mem_busy = 0;
      mem_cnt = 0; done_cnt = 0; sc = 0; prev_sc = 0;
      prev_if = 0; prev_dm = 0; prev_mreq = 0;
      for (int c = 0; c < 3100; c++) begin
         issue = (c < 3000);
         cyc();
         if (issue && !if_pend && !if_out && $urandom_range(0, 2) == 0) begin
            if_pend = 1; if_a = $urandom;
         end
         if (issue && !dm_pend && !dm_out && $urandom_range(0, 2) == 0) begin
            dm_pend = 1; dm_a = $urandom; dm_w = $urandom_range(0, 1);
            dm_b = $urandom; dm_wd = $urandom;
         end
         if_req_i   = if_pend;
         if_addr_i  = if_pend ? if_a : $urandom;
         dm_req_i   = dm_pend;
         dm_addr_i  = dm_pend ? dm_a : $urandom;
         dm_we_i    = dm_pend ? dm_w : 1'($urandom);
         dm_be_i    = dm_pend ? dm_b : 4'($urandom);
         dm_wdata_i = dm_pend ? dm_wd : $urandom;
         mem_rvalid_i = 0; mem_rdata_i = $urandom;
         if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               mem_rvalid_i = 1; mem_busy = 0;
            end
         end
         mem_gnt_i = mem_req_o && ($urandom_range(0, 2) != 0);
         #1;
         if (mem_req_o && !prev_mreq) begin
            exp_fetch = prev_if && (!prev_dm || (GUARD && prev_sc == LIMIT));
            chk("rnd_select", {mem_we_o, mem_addr_o}, exp_fetch ? {1'b0, if_a} : {dm_w, dm_a});
         end
         chk("rnd_rvalid", {if_rvalid_o, dm_rvalid_o}, mem_rvalid_i ? {if_out, dm_out} : 2'b00);
         if (mem_rvalid_i) begin
            chk("rnd_rdata", if_out ? if_rdata_o : dm_rdata_o, mem_rdata_i);
            if_out = 0; dm_out = 0; done_cnt++;
         end
         if (mem_gnt_i) begin
            chk("rnd_gnt_one", if_gnt_o ^ dm_gnt_o, 1);
            if (dm_gnt_o) begin
               chk("rnd_dm_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                   {dm_w, dm_b, dm_a, dm_wd});
               dm_pend = 0; dm_out = 1;
            end else if (if_gnt_o) begin
               chk("rnd_if_fields", {mem_we_o, mem_be_o, mem_addr_o}, {1'b0, 4'hF, if_a});
               if_pend = 0; if_out = 1;
            end
            mem_busy = 1; mem_cnt = $urandom_range(1, 3);
         end else begin
            chk("rnd_gnt_none", {if_gnt_o, dm_gnt_o}, 2'b00);
         end
         prev_sc = sc; prev_if = if_req_i; prev_dm = dm_req_i; prev_mreq = mem_req_o;
         if (!if_req_i || if_gnt_o) sc = 0;
         else if (dm_gnt_o && sc < LIMIT) sc++;
      end
      chk("rnd_drain", {if_pend, dm_pend, if_out, dm_out, busy_o}, 5'b0);
      chk("rnd_progress", done_cnt > 300, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive data grants allowed while fetch waits (used only under MEM_ARB_STARVE_GUARD_EN).
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports clk_i (input, 1, rising-edge clock) and rst_i (input, 1, synchronous active-high reset).
REQ-005 SHALL have the following ports:
- flush_i: input, 1, commit branch-taken flush.
- if_req_i / if_addr_i: input, 1 / ADDR_W, fetch read request.
- if_gnt_o / if_rvalid_o / if_rdata_o: output, 1 / 1 / DATA_W, fetch grant, response valid, response data.
- dm_req_i / dm_we_i / dm_be_i / dm_addr_i / dm_wdata_i: input, 1 / 1 / DATA_W/8 / ADDR_W / DATA_W, data-stage request.
- dm_gnt_o / dm_rvalid_o / dm_rdata_o: output, 1 / 1 / DATA_W, data grant, response valid, response data.
- mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o: output, 1 / 1 / DATA_W/8 / ADDR_W / DATA_W, shared memory port request.
- mem_gnt_i / mem_rvalid_i / mem_rdata_i: input, 1 / 1 / DATA_W, memory grant, response valid, response data.
- busy_o: output, 1, high when the FSM is not IDLE.

Function
REQ-006 SHALL allow at most one outstanding memory transaction; FSM states IDLE, REQ, RSP, DROP.
REQ-007 In IDLE with any request pending, SHALL select an owner, latch its addr/we/be/wdata, and go to REQ next cycle. Fetch requests are latched with we=0 and be=all ones.
REQ-008 Selection SHALL be data over fetch. Fetch SHALL NOT be selected in a cycle where flush_i=1.
REQ-009 In REQ, SHALL drive mem_req_o=1 with the latched fields only. On mem_gnt_i=1, SHALL pulse the owner's gnt_o in the same cycle and go to RSP.
REQ-010 In RSP, on mem_rvalid_i=1, SHALL pulse the owner's rvalid_o, drive rdata_o=mem_rdata_i in the same cycle, and return to IDLE. Writes also complete through rvalid.
REQ-011 Minimum latency SHALL be: req in cycle 0, mem_req_o in cycle 1 (with gnt), rvalid_o in cycle 2. One IDLE bubble SHALL separate back-to-back transactions.
REQ-012 Requesters hold req and fields stable until gnt_o. The arbiter SHALL ignore requester field changes after latching.
REQ-013 On flush_i=1 with fetch owner in REQ and mem_gnt_i=0, SHALL drop mem_req_o next cycle and go to IDLE, with no if_gnt_o.
REQ-014 On flush_i=1 with fetch owner in REQ and mem_gnt_i=1, SHALL suppress if_gnt_o and go to DROP.
REQ-015 On flush_i=1 with fetch owner in RSP, SHALL go to DROP. If mem_rvalid_i=1 in the same cycle, SHALL suppress if_rvalid_o and go to IDLE.
REQ-016 In DROP, SHALL discard mem_rvalid_i (no rvalid_o to anyone) and then go to IDLE.
REQ-017 flush_i SHALL NOT affect a data-owned transaction.
REQ-018 gnt_o and rvalid_o SHALL never be asserted to both requesters in one cycle, and SHALL never be asserted to a non-owner.

Reset
REQ-019 With rst_i=1 at a clock edge, SHALL enter IDLE, clear owner and latched fields, and clear the starve counter.
REQ-020 During and after reset, all outputs SHALL be 0 until a new request is selected.
REQ-021 Reset mid-transaction SHALL abandon it without any rvalid_o; a later stray mem_rvalid_i in IDLE SHALL be ignored.

Configuration
REQ-022 With MEM_ARB_STARVE_GUARD_EN defined:
- A counter SHALL increment on each data grant while if_req_i=1.
- The counter SHALL clear on fetch grant or when if_req_i=0.
- When the counter equals STARVE_LIMIT, IDLE SHALL select fetch over data (flush_i still blocks).
REQ-023 Without MEM_ARB_STARVE_GUARD_EN, SHALL apply strict data priority with no counter logic.

Structure
REQ-024 tartaruga_pkg SHALL hold mem_arb_state_t (IDLE/REQ/RSP/DROP), mem_owner_t (OWN_IF/OWN_DM), and the default STARVE_LIMIT constant.
REQ-025 SHALL be a single module with no sub-module; the FSM, latch and counter are all in mem_arbiter.

Verification
REQ-026 Fetch read 0x100 alone, mem_gnt_i immediate, rvalid 1 cycle later with 0xDEADBEEF -> if_gnt_o in cycle 1, if_rvalid_o with 0xDEADBEEF in cycle 2, busy_o 1 for cycles 1-2.
REQ-027 Fetch 0x100 and data store 0x2000/0x55AA/be=0xF requested together -> mem_addr_o=0x2000, mem_we_o=1 first; fetch served next, after one IDLE bubble.
REQ-028 Fetch owner in RSP, flush_i pulse, rvalid 2 cycles later -> state DROP, no if_rvalid_o, IDLE after rvalid.
REQ-029 Fetch owner in REQ, flush_i with mem_gnt_i=0 -> mem_req_o=0 next cycle, no if_gnt_o. Repeat with a data owner -> transaction completes normally.
REQ-030 Guard enabled, STARVE_LIMIT=4, dm_req_i and if_req_i held high -> exactly 4 data grants, then 1 fetch grant, repeating. Guard disabled -> fetch never granted.
REQ-031 rst_i asserted in RSP, mem_rvalid_i 1 cycle after reset release -> no rvalid_o, all outputs 0, state IDLE.
